// File: rtl/fetch_realign_queue.sv
// rtl/fetch_realign_queue.sv - halfword-granular fetch realign queue between fetch and decode
module fetch_realign_queue #(
  parameter int DEPTH      = 4,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int SLOTS     = 2 * DEPTH,
  localparam int PW        = $clog2(SLOTS),
  localparam int CW        = $clog2(SLOTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_addr_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WORD_WIDTH-1:0] in_data_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           out_instr_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_is_rvc_o,
  output logic [CW-1:0]         count_o
);

  // Halfword storage: instruction bits and the halfword address of each slot
  logic [15:0]           hw_mem   [SLOTS];
  logic [ADDR_WIDTH-1:0] addr_mem [SLOTS];

  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic          skip;

  logic [15:0]           hw0;
  logic [15:0]           hw1;
  logic                  head_rvc;
  logic                  has1;
  logic                  has2;
  logic                  wr_en;
  logic                  rd_en;
  logic [CW-1:0]         wr_n;
  logic [CW-1:0]         rd_n;
  logic [ADDR_WIDTH-1:0] lo_addr;
  logic [ADDR_WIDTH-1:0] hi_addr;
  logic                  flush_skip;

  // Head decode, handshakes and per-cycle halfword transfer amounts
  always_comb begin
    hw0          = hw_mem[rptr];
    hw1          = hw_mem[rptr + PW'(1)];
    head_rvc     = (hw0[1:0] != 2'b11);
    has1         = (count != '0);
    has2         = (count >= CW'(2));
    out_valid_o  = (has1 & head_rvc) | has2;
    out_is_rvc_o = has1 & head_rvc;
    out_instr_o  = head_rvc ? {16'h0000, hw0} : {hw1, hw0};
    out_addr_o   = addr_mem[rptr];
    count_o      = count;
    // Room for a whole word is needed even when only the high half will be kept
    in_ready_o   = (count <= CW'(SLOTS - 2));
    wr_en        = in_valid_i & in_ready_o & ~flush_i;
    rd_en        = out_valid_o & out_ready_i & ~flush_i;
    wr_n         = '0;
    if (wr_en) wr_n = skip ? CW'(1) : CW'(2);
    rd_n         = '0;
    if (rd_en) rd_n = head_rvc ? CW'(1) : CW'(2);
    lo_addr      = in_addr_i & ~ADDR_WIDTH'(3);
    hi_addr      = lo_addr | ADDR_WIDTH'(2);
    flush_skip   = |(flush_addr_i & ADDR_WIDTH'(2));
  end

  // Pointer, occupancy and skip-flag state; flush overrides any transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      skip  <= 1'b0;
    end else if (flush_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      skip  <= flush_skip;
    end else begin
      wptr  <= wptr + PW'(wr_n);
      rptr  <= rptr + PW'(rd_n);
      count <= count + wr_n - rd_n;
      if (wr_en) skip <= 1'b0;
    end
  end

  // Halfword writes; after a mid-word restart only the upper halfword is kept
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (skip) begin
        hw_mem[wptr]   <= in_data_i[31:16];
        addr_mem[wptr] <= hi_addr;
      end else begin
        hw_mem[wptr]             <= in_data_i[15:0];
        addr_mem[wptr]           <= lo_addr;
        hw_mem[wptr + PW'(1)]    <= in_data_i[31:16];
        addr_mem[wptr + PW'(1)]  <= hi_addr;
      end
    end
  end

endmodule
